// File: rtl/bcd_convert_scheduler.sv
// Round-robin front end sharing one shift-add-3 binary-to-BCD engine.
// One operand bit per clock; result tagged with the requester ID.
module bcd_convert_scheduler #(
  parameter int WIDTH  = 14,
  parameter int DIGITS = 5,
  parameter int NREQ   = 4,
  parameter int IDW    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   bin_flat,
  output logic [NREQ-1:0]         grant,
  output logic                    busy,
  output logic                    done,
  output logic [IDW-1:0]          done_id,
  output logic [DIGITS*4-1:0]     bcd
);

  localparam int DW = DIGITS * 4;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [DW-1:0]     work_q, work_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [DW-1:0]     bcd_q, bcd_d;

  logic [DW-1:0]     adj;
  logic [DW-1:0]     shifted;
  logic              found;
  logic [IDW-1:0]    win;
  logic [WIDTH-1:0]  win_op;

  always_comb begin
    adj = work_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
    shifted = {adj[DW-2:0], sreg_q[WIDTH-1]};
  end

  // First requester strictly after the last winner, wrapping around.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_op = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!found && req[(int'(rr_q) + i) % NREQ]) begin
        found  = 1'b1;
        win    = IDW'((int'(rr_q) + i) % NREQ);
        win_op = bin_flat[((int'(rr_q) + i) % NREQ) * WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    grant_d   = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    bcd_d     = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = SHIFT;
          sreg_d       = win_op;
          work_d       = '0;
          cnt_d        = CW'(WIDTH - 1);
          rr_d         = win;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
        end
      end
      SHIFT: begin
        work_d = shifted;
        sreg_d = sreg_q << 1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d   = DONE;
          bcd_d     = shifted;
          done_d    = 1'b1;
          done_id_d = rr_q;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      rr_q      <= IDW'(NREQ - 1);
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      bcd_q     <= bcd_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign bcd     = bcd_q;

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Bench for bcd_convert_scheduler: decimal reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_bcd_convert_scheduler;

  localparam int WIDTH  = 14;
  localparam int DIGITS = 5;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] bin_flat;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [DIGITS*4-1:0]   bcd;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bcd_convert_scheduler #(
    .WIDTH(WIDTH), .DIGITS(DIGITS), .NREQ(NREQ), .IDW(IDW)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .bin_flat(bin_flat),
    .grant(grant), .busy(busy), .done(done),
    .done_id(done_id), .bcd(bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int i = 1; i <= NREQ; i++) begin
      if (r[(last + i) % NREQ]) return (last + i) % NREQ;
    end
    return 0;
  endfunction

  function automatic logic [DIGITS*4-1:0] to_bcd(input int v);
    logic [DIGITS*4-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Model: phase counts clocks since the accept edge (0 = idle).
  int                  m_phase = 0;
  int                  m_last = NREQ - 1;
  int                  m_win = 0;
  int                  m_op = 0;
  int                  m_id = 0;
  logic [DIGITS*4-1:0] m_bcd = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_last  <= NREQ - 1;
      m_bcd   <= '0;
      m_id    <= 0;
    end else if (m_phase == 0) begin
      if (|req) begin
        m_win   <= rr_pick(req, m_last);
        m_last  <= rr_pick(req, m_last);
        m_op    <= int'(bin_flat[rr_pick(req, m_last)*WIDTH +: WIDTH]);
        m_phase <= 1;
      end
    end else if (m_phase == WIDTH) begin
      m_bcd   <= to_bcd(m_op);
      m_id    <= m_win;
      m_phase <= m_phase + 1;
    end else if (m_phase == WIDTH + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  always @(negedge clk) begin
    chk("grant", 32'(grant), (m_phase == 1) ? 32'(1 << m_win) : 32'd0);
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("done", 32'(done), 32'(m_phase == WIDTH + 1));
    chk("done_id", 32'(done_id), 32'(m_id));
    chk("bcd", 32'(bcd), 32'(m_bcd));
  end

  task automatic rand_ops();
    for (int s = 0; s < NREQ; s++) begin
      bin_flat[s*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 16383));
    end
  endtask

  // One conversion from idle; optional operand change two cycles after grant.
  task automatic conv(input logic [NREQ-1:0] rmask, input int win,
                      input int val, input int late,
                      input logic [DIGITS*4-1:0] exp);
    int n;
    @(posedge clk);
    #1;
    bin_flat[win*WIDTH +: WIDTH] = WIDTH'(val);
    req = rmask;
    @(posedge clk);
    @(negedge clk);
    chk("d_grant", 32'(grant), 32'(1 << win));
    req = '0;
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3 && late >= 0) bin_flat[win*WIDTH +: WIDTH] = WIDTH'(late);
    end
    chk("d_latency", 32'(n), 32'd15);
    chk("d_bcd", 32'(bcd), 32'(exp));
    chk("d_id", 32'(done_id), 32'(win));
  endtask

  logic [DIGITS*4-1:0] exp3 [4];
  int n;
  int prev;

  initial begin
    exp3 = '{20'h00001, 20'h00022, 20'h00333, 20'h04444};
    req = '0;
    bin_flat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    conv(4'b0001, 0, 16383, -1, 20'h16383);
    conv(4'b0010, 1, 0, -1, 20'h00000);
    conv(4'b0010, 1, 9999, -1, 20'h09999);

    // Restore priority to requester 0, then all four request together.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    bin_flat = {14'd4444, 14'd333, 14'd22, 14'd1};
    req = 4'hF;
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n = 0;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("rr_done_seen", 32'(done), 32'd1);
      chk("rr_id", 32'(done_id), 32'(i % 4));
      chk("rr_bcd", 32'(bcd), 32'(exp3[i % 4]));
      if (i > 0) chk("rr_gap", 32'(cyc - prev), 32'd16);
      prev = cyc;
    end
    req = '0;

    conv(4'b0001, 0, 1234, 5678, 20'h01234);

    // Reset in the middle of a conversion.
    @(posedge clk);
    #1;
    bin_flat[1*WIDTH +: WIDTH] = 14'd777;
    req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_bcd", 32'(bcd), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    conv(4'b1010, 1, 42, -1, 20'h00042);
    conv(4'b0100, 2, 555, -1, 20'h00555);

    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      rand_ops();
      if (i % 50 == 0) bin_flat[0 +: WIDTH] = 14'd16383;
      if (i % 50 == 25) bin_flat[0 +: WIDTH] = 14'd0;
      req = NREQ'($urandom_range(1, 15));
      @(posedge clk);
      @(negedge clk);
      req = NREQ'($urandom_range(0, 15));
      n = 1;
      while (done !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
        if (n == 5) rand_ops();
      end
      chk("rand_done_seen", 32'(done), 32'd1);
    end
    req = '0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
